// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor built around one full_subtractor cell
//
// Purpose : computes diff = a - b (mod 2^WIDTH), LSB first, one bit per clock.
//           Start at edge E0, bits at E1..E_WIDTH, result and done in the following cycle.
// Macro   : SERIAL_SUBTRACTOR_OVF_EN adds the registered signed-overflow output ovf.
// Ports   : clk        rising-edge clock
//           rst        asynchronous active-high reset
//           start      operation request, sampled only in IDLE
//           a, b       minuend / subtrahend, captured at the accepted start edge
//           busy       high while in SHIFT or DONE
//           done       one-cycle completion pulse
//           diff       registered result, held until the next completion
//           borrow_out final borrow, 1 iff a < b (unsigned)
//           ovf        (optional) two's-complement overflow of a - b

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b ^ cin;
  assign borrow = (~a & (b | cin)) | (b & cin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_b;
  logic             last_bit;
  logic             d_lsb_unused;

  full_subtractor u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (brw),
    .diff  (cell_d),
    .borrow(cell_b)
  );

  assign last_bit = (state == S_SHIFT) && (cnt == LAST);

  // The oldest result bit falls off the end when the final word is formed.
  assign d_lsb_unused = d_sh[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        brw  <= 1'b0;
        cnt  <= '0;
      end else if (state == S_SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        d_sh <= {cell_d, d_sh[WIDTH-1:1]};
        brw  <= cell_b;
        cnt  <= cnt + CW'(1);
      end
      if (last_bit) begin
        diff       <= {cell_d, d_sh[WIDTH-1:1]};
        borrow_out <= cell_b;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // On the last bit the shifters present the original operand MSBs at bit 0
  // and the cell is producing the result MSB, so no extra capture is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2)

module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, busy, done, borrow_out;
  logic [W-1:0] a, b, diff;
  logic         start2, busy2, done2, bo2;
  logic [1:0]   a2, b2, diff2;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf, ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_exp;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf2)
`endif
  );

  // Reference model: plain integer arithmetic on the operand values.
  function automatic int ref_diff(input int av, input int bv, input int w);
    int m;
    m = 1 << w;
    return ((av - bv) % m + m) % m;
  endfunction

  function automatic logic ref_borrow(input int av, input int bv);
    return av < bv;
  endfunction

  function automatic logic ref_ovf(input int av, input int bv, input int w);
    int half, sa, sb, r;
    half = 1 << (w - 1);
    sa = (av >= half) ? av - 2 * half : av;
    sb = (bv >= half) ? bv - 2 * half : bv;
    r  = sa - sb;
    return (r < -half) || (r > half - 1);
  endfunction

  // Launches one operation and observes it; starts and ends on a falling edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        output int lat, output int busy_n, output int done_n,
                        output logic [W-1:0] d, output logic [W-1:0] d0,
                        output logic bo, output logic ov);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = -1; busy_n = 0; done_n = 0; d = '0; bo = 1'b0; ov = 1'b0;
    d0 = diff;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = i; d = diff; bo = borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ov = ovf;
`endif
        end
      end
      if (!busy && i > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (diff !== '0) begin n_err++; $display("FAIL reset_diff: got %h want 00", diff); end
    n_cmp++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL reset_borrow: got %b want 0", borrow_out); end
    n_cmp++; if (busy2 !== 1'b0 || diff2 !== 2'b0) begin n_err++; $display("FAIL reset_w2: busy %b diff %h want 0/0", busy2, diff2); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bn, dn; logic [W-1:0] d, d0; logic bo, ov;
    run_op(8'd100, 8'd37, lat, bn, dn, d, d0, bo, ov);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++; if (d !== 8'd63) begin n_err++; $display("FAIL basic_diff: got %0d want 63", d); end
    n_cmp++; if (bo !== 1'b0) begin n_err++; $display("FAIL basic_borrow: got %b want 0", bo); end
    n_cmp++; if (bn !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 9", bn); end
    n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL basic_done_cycles: got %0d want 1", dn); end
    last_exp = 8'd63;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [6] = '{8'd5, 8'd0, 8'hA5, 8'hFF, 8'd0, 8'h7F};
    logic [W-1:0] tb [6] = '{8'd9, 8'hFF, 8'hA5, 8'd0, 8'd1, 8'h80};
    int lat, bn, dn; logic [W-1:0] d, d0; logic bo, ov;
    for (int k = 0; k < 6; k++) begin
      run_op(ta[k], tb[k], lat, bn, dn, d, d0, bo, ov);
      n_cmp++; if (d0 !== last_exp) begin n_err++; $display("FAIL bnd_hold[%0d]: got %h want %h", k, d0, last_exp); end
      n_cmp++; if (d !== W'(ref_diff(ta[k], tb[k], W))) begin n_err++; $display("FAIL bnd_diff[%0d]: got %h want %h", k, d, ref_diff(ta[k], tb[k], W)); end
      n_cmp++; if (bo !== ref_borrow(ta[k], tb[k])) begin n_err++; $display("FAIL bnd_borrow[%0d]: got %b want %b", k, bo, ref_borrow(ta[k], tb[k])); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_cmp++; if (ov !== ref_ovf(ta[k], tb[k], W)) begin n_err++; $display("FAIL bnd_ovf[%0d]: got %b want %b", k, ov, ref_ovf(ta[k], tb[k], W)); end
`endif
      last_exp = W'(ref_diff(ta[k], tb[k], W));
    end
  endtask

  task automatic test_ignored_start();
    int dn; logic [W-1:0] d;
    dn = 0; d = '0;
    @(negedge clk);
    a = 8'd20; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin dn++; d = diff; end
      if (i == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", dn); end
    n_cmp++; if (d !== 8'd17) begin n_err++; $display("FAIL ign_diff: got %0d want 17", d); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle: busy %b want 0", busy); end
    n_cmp++; if (diff !== 8'd17) begin n_err++; $display("FAIL ign_diff_hold: got %0d want 17", diff); end
    last_exp = 8'd17;
  endtask

  task automatic test_async_reset();
    int dn, lat, bn, dn2; logic [W-1:0] d, d0; logic bo, ov;
    @(negedge clk);
    a = 8'd77; b = 8'd22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b want 0", done); end
    n_cmp++; if (diff !== '0) begin n_err++; $display("FAIL arst_diff: got %h want 00", diff); end
    n_cmp++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL arst_borrow: got %b want 0", borrow_out); end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL arst_no_done: got %0d active cycles want 0", dn); end
    run_op(8'd9, 8'd4, lat, bn, dn2, d, d0, bo, ov);
    n_cmp++; if (d !== 8'd5 || lat !== 8) begin n_err++; $display("FAIL arst_after: diff %0d lat %0d want 5/8", d, lat); end
    last_exp = 8'd5;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av [31];
    logic [W-1:0] bv [31];
    int dpos [$];
    logic [W-1:0] dval [$];
    logic bval [$];
    @(negedge clk);
    av[0] = W'($urandom); bv[0] = W'($urandom);
    a = av[0]; b = bv[0]; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin dpos.push_back(c); dval.push_back(diff); bval.push_back(borrow_out); end
      av[c+1] = W'($urandom); bv[c+1] = W'($urandom);
      a = av[c+1]; b = bv[c+1];
      if (c == 29) start = 1'b0;
    end
    repeat (12) @(negedge clk);
    n_cmp++; if (dpos.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", dpos.size()); end
    for (int k = 0; k < 3 && k < dpos.size(); k++) begin
      n_cmp++; if (dpos[k] !== 10 * k + 8) begin n_err++; $display("FAIL b2b_pos[%0d]: got %0d want %0d", k, dpos[k], 10 * k + 8); end
      n_cmp++; if (dval[k] !== W'(ref_diff(av[10*k], bv[10*k], W)) || bval[k] !== ref_borrow(av[10*k], bv[10*k]))
        begin n_err++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", k, dval[k], bval[k], ref_diff(av[10*k], bv[10*k], W), ref_borrow(av[10*k], bv[10*k])); end
    end
  endtask

  task automatic test_random();
    int lat, bn, dn; logic [W-1:0] d, d0, ra, rb; logic bo, ov;
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom); rb = W'($urandom);
      run_op(ra, rb, lat, bn, dn, d, d0, bo, ov);
      n_cmp++; if (d !== W'(ref_diff(ra, rb, W)) || bo !== ref_borrow(ra, rb) || lat !== 8)
        begin n_err++; $display("FAIL rand[%0d] a=%h b=%h: got %h/%b lat %0d want %h/%b lat 8", k, ra, rb, d, bo, lat, ref_diff(ra, rb, W), ref_borrow(ra, rb)); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_cmp++; if (ov !== ref_ovf(ra, rb, W)) begin n_err++; $display("FAIL rand_ovf[%0d]: got %b want %b", k, ov, ref_ovf(ra, rb, W)); end
`endif
    end
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    int lat, bn, dn; logic [W-1:0] d, d0; logic bo, ov;
    run_op(8'h80, 8'h01, lat, bn, dn, d, d0, bo, ov);
    n_cmp++; if (d !== 8'h7F || ov !== 1'b1) begin n_err++; $display("FAIL ovf_80_01: got %h/%b want 7f/1", d, ov); end
    run_op(8'h10, 8'h01, lat, bn, dn, d, d0, bo, ov);
    n_cmp++; if (d !== 8'h0F || ov !== 1'b0) begin n_err++; $display("FAIL ovf_10_01: got %h/%b want 0f/0", d, ov); end
  endtask
`endif

  task automatic test_w2_sweep();
    int lat; logic [1:0] d; logic bo, ov;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        @(negedge clk);
        a2 = 2'(x); b2 = 2'(y); start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
        lat = -1; d = '0; bo = 1'b0; ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (done2) begin
            lat = i; d = diff2; bo = bo2;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ov = ovf2;
`endif
            break;
          end
          @(negedge clk);
        end
        @(negedge clk);
        n_cmp++; if (lat !== 2 || d !== 2'(ref_diff(x, y, 2)) || bo !== ref_borrow(x, y))
          begin n_err++; $display("FAIL w2[%0d-%0d]: got %h/%b lat %0d want %h/%b lat 2", x, y, d, bo, lat, ref_diff(x, y, 2), ref_borrow(x, y)); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        n_cmp++; if (ov !== ref_ovf(x, y, 2)) begin n_err++; $display("FAIL w2_ovf[%0d-%0d]: got %b want %b", x, y, ov, ref_ovf(x, y, 2)); end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    last_exp = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    test_w2_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
